// File: rtl/div8_4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// A zero divisor short-circuits to DONE with Q=8'hFF, R=N[3:0] and div_zero set.
module div8_4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] N,
  input  logic [3:0] D,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  logic [7:0]  n_r;
  logic [3:0]  d_r;
  logic [3:0]  pr_r;
  logic [6:0]  q_acc_r;
  logic [2:0]  cnt_r;

  logic [7:0]  q_r;
  logic [3:0]  r_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic        n_bit_s;
  logic [4:0]  pr_shift_s;
  logic [3:0]  pr_diff_s;
  logic [3:0]  pr_next_s;
  logic        q_bit_s;

  // Next-state decode for the IDLE/CALC/DONE sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (D != 4'd0) begin
            state_nx_s = CALC;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 3'd7) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = CALC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One restoring step; the stored remainder is always below D, so the
  // difference is exact in 4 bits whenever the subtraction is taken.
  always_comb begin
    n_bit_s    = n_r[3'd7 - cnt_r];
    pr_shift_s = {pr_r, n_bit_s};
    pr_diff_s  = pr_shift_s[3:0] - d_r;
    q_bit_s    = 1'b0;
    pr_next_s  = pr_shift_s[3:0];
    if (pr_shift_s >= {1'b0, d_r}) begin
      q_bit_s   = 1'b1;
      pr_next_s = pr_diff_s;
    end else begin
      q_bit_s   = 1'b0;
      pr_next_s = pr_shift_s[3:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r     <= 8'd0;
      d_r     <= 4'd0;
      pr_r    <= 4'd0;
      q_acc_r <= 7'd0;
      cnt_r   <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            n_r     <= N;
            d_r     <= D;
            pr_r    <= 4'd0;
            q_acc_r <= 7'd0;
            cnt_r   <= 3'd0;
          end
        end
        CALC: begin
          pr_r    <= pr_next_s;
          q_acc_r <= {q_acc_r[5:0], q_bit_s};
          cnt_r   <= cnt_r + 3'd1;
        end
        default: begin
          pr_r <= pr_r;
        end
      endcase
    end
  end

  // Registered status and result; results change only on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= 8'd0;
      r_r        <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == CALC);
      done_r <= (state_nx_s == DONE);
      if (state_nx_s == DONE && state_r == CALC) begin
        q_r        <= {q_acc_r, q_bit_s};
        r_r        <= pr_next_s;
        div_zero_r <= 1'b0;
      end else if (state_nx_s == DONE && state_r == IDLE) begin
        q_r        <= 8'hFF;
        r_r        <= N[3:0];
        div_zero_r <= 1'b1;
      end
    end
  end

  assign Q        = q_r;
  assign R        = r_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule
